// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
package uart_frame_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] SYNC0_DEF = 8'hA5;
    localparam logic [BYTE_W-1:0] SYNC1_DEF = 8'h5A;

    typedef enum logic [2:0] {
        StHunt1,
        StHunt2,
        StLen,
        StPayload,
        StCsum,
        StDrain
    } state_e;

    // Width needed to hold a LEN value in 0..max_len.
    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: one synchronous write port, one combinational read port.
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned AW      = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [BYTE_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [BYTE_W-1:0] o_rdata
);

    logic [BYTE_W-1:0] r_mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Sync-hunting, length-prefixed, checksummed frame parser behind a UART byte receiver.
// Define FRAME_TIMEOUT_EN to abort stalled frames after TIMEOUT idle cycles.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int unsigned       MAX_LEN = 16,
    parameter logic [BYTE_W-1:0] SYNC0   = SYNC0_DEF,
    parameter logic [BYTE_W-1:0] SYNC1   = SYNC1_DEF,
    parameter int unsigned       TIMEOUT = 800,
    parameter int unsigned       LW      = len_width(MAX_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] iData,
    input  logic              iValid,
    output logic [BYTE_W-1:0] oData,
    output logic              oValid,
    input  logic              iReady,
    output logic              oLast,
    output logic [LW-1:0]     oLen,
    output logic              oFrameErr,
    output logic              oOverrun,
    output logic              oBusy
);

    localparam int unsigned AW = $clog2(MAX_LEN);

    state_e            r_state, w_state_next;
    logic              r_valid_q;
    logic              r_strobe;
    logic [BYTE_W-1:0] r_byte;
    logic [LW-1:0]     r_len, w_len_next;
    logic [BYTE_W-1:0] r_sum, w_sum_next;
    logic [AW-1:0]     r_idx, w_idx_next;
    logic [AW-1:0]     r_rd, w_rd_next;
    logic              r_frame_err, w_frame_err;
    logic              r_overrun, w_overrun;
    logic              w_we;
    logic              w_timeout;
    logic              w_len_ok;
    logic              w_xfer;
    logic              w_last;
    logic [LW-1:0]     w_last_idx;
    logic [BYTE_W-1:0] w_rd_data;

    uart_frame_buf #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (r_byte),
        .i_raddr (r_rd),
        .o_rdata (w_rd_data)
    );

`ifdef FRAME_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_idle;
    logic          w_counting;

    assign w_counting = (r_state != StHunt1) && (r_state != StDrain);
    assign w_timeout  = w_counting && !r_strobe && (r_idle == TW'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle <= '0;
        end else if (r_strobe || !w_counting) begin
            r_idle <= '0;
        end else if (r_idle != TW'(TIMEOUT)) begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StHunt1;
            r_valid_q   <= 1'b0;
            r_strobe    <= 1'b0;
            r_byte      <= '0;
            r_len       <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_rd        <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_valid_q   <= iValid;
            // One strobe per byte, however long iValid stays high.
            r_strobe    <= iValid & ~r_valid_q;
            if (iValid & ~r_valid_q) begin
                r_byte <= iData;
            end
            r_state     <= w_state_next;
            r_len       <= w_len_next;
            r_sum       <= w_sum_next;
            r_idx       <= w_idx_next;
            r_rd        <= w_rd_next;
            r_frame_err <= w_frame_err;
            r_overrun   <= w_overrun;
        end
    end

    assign w_last_idx = r_len - LW'(1);
    assign w_len_ok   = (r_byte != '0) && (r_byte <= BYTE_W'(MAX_LEN));
    assign oValid     = (r_state == StDrain);
    assign w_last     = oValid && (LW'(r_rd) == w_last_idx);
    assign w_xfer     = oValid && iReady;
    assign oData      = oValid ? w_rd_data : '0;
    assign oLast      = w_last;
    assign oLen       = r_len;
    assign oFrameErr  = r_frame_err;
    assign oOverrun   = r_overrun;
    assign oBusy      = (r_state != StHunt1);

    always_comb begin
        w_state_next = r_state;
        w_len_next   = r_len;
        w_sum_next   = r_sum;
        w_idx_next   = r_idx;
        w_rd_next    = r_rd;
        w_we         = 1'b0;
        w_frame_err  = 1'b0;
        w_overrun    = 1'b0;

        if (w_timeout) begin
            w_frame_err  = 1'b1;
            w_state_next = StHunt1;
        end else begin
            unique case (r_state)
                StHunt1: begin
                    if (r_strobe && r_byte == SYNC0) begin
                        w_state_next = StHunt2;
                    end
                end
                StHunt2: begin
                    if (r_strobe) begin
                        if (r_byte == SYNC1) begin
                            w_state_next = StLen;
                        end else if (r_byte != SYNC0) begin
                            w_state_next = StHunt1;
                        end
                    end
                end
                StLen: begin
                    if (r_strobe) begin
                        if (w_len_ok) begin
                            w_len_next   = LW'(r_byte);
                            w_sum_next   = r_byte;
                            w_idx_next   = '0;
                            w_state_next = StPayload;
                        end else begin
                            w_frame_err  = 1'b1;
                            w_state_next = StHunt1;
                        end
                    end
                end
                StPayload: begin
                    if (r_strobe) begin
                        w_we       = 1'b1;
                        w_sum_next = r_sum + r_byte;
                        if (LW'(r_idx) == w_last_idx) begin
                            w_state_next = StCsum;
                        end else begin
                            w_idx_next = r_idx + 1'b1;
                        end
                    end
                end
                StCsum: begin
                    if (r_strobe) begin
                        if (BYTE_W'(r_sum + r_byte) == '0) begin
                            w_rd_next    = '0;
                            w_state_next = StDrain;
                        end else begin
                            w_frame_err  = 1'b1;
                            w_state_next = StHunt1;
                        end
                    end
                end
                StDrain: begin
                    w_overrun = r_strobe;
                    if (w_xfer) begin
                        if (w_last) begin
                            w_state_next = StHunt1;
                        end else begin
                            w_rd_next = r_rd + 1'b1;
                        end
                    end
                end
                default: w_state_next = StHunt1;
            endcase
        end
    end

endmodule
